con_resp_framer: RTL
====================

// Module: con_resp_framer
// PURPOSE
//  Downstream stage of the reconfig response path. Captures each contiguous con_din_en byte burst
//  (e.g. the 15-byte reconfig status reply) into a single-packet buffer. Appends an 8-bit modulo-256
//  sum checksum and streams packet+checksum to the UART TX over a valid/ready handshake.
//  Sits between the con_dout producers and the serial transmitter.
// PARAMETERS
//  MAX_LEN   32   max payload bytes per packet (2..255); buffer depth
//  AW        5    buffer address width, 2**AW >= MAX_LEN
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  con_din     in   8  payload byte, valid when con_din_en=1
//  con_din_en  in   1  burst strobe; one byte per cycle while high, burst ends when it drops
//  tx_data     out  8  byte to transmitter
//  tx_valid    out  1  tx_data valid
//  tx_ready    in   1  transmitter accepts byte when tx_valid&&tx_ready
//  tx_last     out  1  high with the checksum byte (final byte of packet)
//  busy        out  1  high in any state other than IDLE
//  pkt_cnt     out  8  packets fully sent, wraps 255->0
//  drop_cnt    out  8  bursts discarded (overflow or arrived while busy), saturates at 255
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, tx_data=0, tx_valid=0, tx_last=0, busy=0, pkt_cnt=0,
//   drop_cnt=0, wr_cnt=0, rd_ptr=0, csum=0, ovf=0. Deasserting rst_n mid-packet loses the packet.
//   No partial output follows reset.
//  States: IDLE, RECV, SEND, CSUM, DISCARD.
//  IDLE: con_din_en=1 -> write byte at addr 0, wr_cnt=1, csum=con_din, go RECV.
//  RECV: con_din_en=1 and wr_cnt<MAX_LEN -> write at wr_cnt, wr_cnt+1, csum+=con_din (8-bit wrap).
//   con_din_en=1 and wr_cnt==MAX_LEN -> ovf=1, byte dropped.
//   con_din_en=0 -> burst end. ovf=0: go SEND, rd_ptr=0. ovf=1: drop_cnt+1, clear ovf, go IDLE.
//  SEND: tx_valid=1, tx_data=buf[rd_ptr], tx_last=0. Output is registered, so the first byte is
//   valid 1 cycle after burst end is detected.
//   Handshake: tx_data/tx_valid hold stable until tx_valid&&tx_ready.
//   On accept: rd_ptr+1. After byte wr_cnt-1 is accepted -> CSUM.
//  CSUM: tx_data=csum, tx_valid=1, tx_last=1. On accept: tx_valid=0, tx_last=0, pkt_cnt+1, IDLE.
//  DISCARD: entered from SEND/CSUM when con_din_en rises.
//   The current transmission continues unaffected (state tracked via flag, not by abandoning SEND).
//   The incoming burst is ignored entirely; drop_cnt+1 once per burst, counted on its first byte.
//   A burst that is still high when CSUM completes stays ignored until con_din_en drops.
//   Implementation: 'ign' flag set on con_din_en rise while busy, cleared on con_din_en=0.
//   IDLE does not accept bytes while ign=1.
//  Back-to-back bursts: a gap of >=1 low cycle separates packets.
//   A burst beginning in the same cycle the CSUM byte is accepted is ignored and counted in drop_cnt.
//   The first accepting cycle is the cycle after IDLE is reached.
//  tx_ready may be held high permanently: one byte per cycle, no bubbles between payload and checksum.
//  drop_cnt saturates at 8'hFF; pkt_cnt wraps.
// TESTING
//  T1 burst 01 02 03, tx_ready=1 -> tx 01 02 03 06, tx_last only on 06, pkt_cnt=1, drop_cnt=0.
//  T2 15-byte burst 04 32 00..00 FF FF FF FF AA 5A 11, tx_ready toggling 1010 -> bytes in order,
//     data stable while stalled, checksum = 8-bit sum of the payload, tx_last on the 16th byte.
//  T3 MAX_LEN+1 (33) byte burst -> no tx_valid ever, drop_cnt=1, next 2-byte burst 10 20 -> 10 20 30.
//  T4 second burst AA BB during SEND with tx_ready=0 -> first packet completes intact, no AA/BB out,
//     drop_cnt=1, busy falls after checksum.
//  T5 rst_n pulsed low mid-SEND -> tx_valid=0 immediately (async), all counters 0, next burst ok.
//  T6 checksum wrap: burst FF FF 03 -> tx FF FF 03 01.

Source files
------------

// File: rtl/con_resp_framer.sv
// Reconfig response framer: buffers one con_din burst, appends a mod-256 sum,
// and streams packet + checksum to the UART TX over valid/ready.
module con_resp_framer #(
    parameter int MAX_LEN = 32,
    parameter int AW      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] con_din,
    input  logic       con_din_en,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       busy,
    output logic [7:0] pkt_cnt,
    output logic [7:0] drop_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] CSUM = 2'd3;

    localparam logic [AW:0] MAXC = (AW+1)'(MAX_LEN);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [1:0]    state;
    logic [AW:0]   wr_cnt;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    csum;
    logic          ovf;
    logic          ign;
    logic [7:0]    mem [0:(1<<AW)-1];

    logic          accept;
    logic          tx_phase;
    logic          ign_hit;
    logic          ovf_end;
    logic          drop_inc;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW:0]   rd_nxt;

    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign tx_phase = (state == SEND) || (state == CSUM);
    // A burst seen while transmitting is swallowed whole, counted once.
    assign ign_hit  = tx_phase && con_din_en && !ign;
    assign ovf_end  = (state == RECV) && !con_din_en && ovf;
    assign drop_inc = ign_hit || ovf_end;
    assign rd_nxt   = {1'b0, rd_ptr} + ONE;

    assign we = ((state == IDLE) && con_din_en && !ign) ||
                ((state == RECV) && con_din_en && (wr_cnt < MAXC));
    assign waddr = (state == IDLE) ? '0 : wr_cnt[AW-1:0];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= con_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            pkt_cnt  <= 8'd0;
            drop_cnt <= 8'd0;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            csum     <= 8'd0;
            ovf      <= 1'b0;
            ign      <= 1'b0;
        end else begin
            if (!con_din_en) ign <= 1'b0;
            else if (ign_hit) ign <= 1'b1;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (con_din_en && !ign) begin
                        wr_cnt <= ONE;
                        csum   <= con_din;
                        ovf    <= 1'b0;
                        state  <= RECV;
                    end
                end
                RECV: begin
                    if (con_din_en) begin
                        if (wr_cnt < MAXC) begin
                            wr_cnt <= wr_cnt + ONE;
                            csum   <= csum + con_din;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else if (ovf) begin
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rd_ptr   <= '0;
                        tx_data  <= mem['0];
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (rd_nxt == wr_cnt) begin
                            tx_data <= csum;
                            tx_last <= 1'b1;
                            state   <= CSUM;
                        end else begin
                            rd_ptr  <= rd_nxt[AW-1:0];
                            tx_data <= mem[rd_nxt[AW-1:0]];
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        pkt_cnt  <= pkt_cnt + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
